alu128_seq_ctrl: RTL and testbench

ALU128_SEQ_CTRL -- requirements
Module: alu128_seq_ctrl

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_8bit.sv | 60 ++++++
 rtl/alu128_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alu128_seq_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sliced 128-bit ALU: opcode encoding, widths,
// controller states and an opcode classification helper.
package alu_pkg;

    localparam int WIDTH  = 128;
    localparam int DWIDTH = 8;
    localparam int NSLICE = 16;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUBWB  = 4'h1,
        OP_MOV    = 4'h2,
        OP_SUB    = 4'h3,
        OP_INC    = 4'h4,
        OP_DEC    = 4'h5,
        OP_ADDINC = 4'h6,
        OP_AND    = 4'h8,
        OP_OR     = 4'h9,
        OP_XOR    = 4'hA,
        OP_NOT    = 4'hB,
        OP_SHL    = 4'hD
    } optype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Arithmetic ops report carry/borrow and overflow from the top slice
    function automatic logic is_arith(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUBWB, OP_SUB, OP_INC, OP_DEC, OP_ADDINC: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU slice; c is carry for additions and borrow for
// subtractions, o is signed overflow.
module alu_8bit
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       c,
    output logic       o
);

    logic [8:0] sum_s;

    // Slice operation decode
    always_comb begin
        sum_s = 9'h000;
        y     = 8'h00;
        c     = 1'b0;
        o     = 1'b0;
        case (op)
            OP_ADD, OP_ADDINC: begin
                sum_s = {1'b0, a} + {1'b0, b} + ((op == OP_ADDINC) ? 9'd1 : 9'd0);
                y     = sum_s[7:0];
                c     = sum_s[8];
                o     = (a[7] == b[7]) && (sum_s[7] != a[7]);
            end
            OP_SUB, OP_SUBWB: begin
                sum_s = {1'b0, a} - {1'b0, b} - ((op == OP_SUBWB) ? 9'd1 : 9'd0);
                y     = sum_s[7:0];
                c     = sum_s[8];
                o     = (a[7] != b[7]) && (sum_s[7] != a[7]);
            end
            OP_INC: begin
                sum_s = {1'b0, a} + 9'd1;
                y     = sum_s[7:0];
                c     = sum_s[8];
                o     = (a == 8'h7F);
            end
            OP_DEC: begin
                sum_s = {1'b0, a} - 9'd1;
                y     = sum_s[7:0];
                c     = sum_s[8];
                o     = (a == 8'h80);
            end
            OP_MOV: y = a;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y = {a[6:0], 1'b0};
                c = a[7];
            end
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu128_seq_ctrl.sv
// 128-bit ALU executed as sixteen 8-bit slices, one per cycle, through a
// single alu_8bit; result and flags update together with the done pulse.
module alu128_seq_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              c_flag,
    output logic              z_flag,
    output logic              o_flag,
    output logic              s_flag
);

    state_e           state_r, state_s;
    logic [3:0]       k_r, op_r;
    logic [WIDTH-1:0] a_r, b_r, shadow_r;
    logic             carry_r, zacc_r;

    logic [6:0]       base_s, prev_idx_s;
    logic [3:0]       slice_op_s;
    logic [7:0]       slice_a_s, slice_b_s, alu_y_s, slice_res_s;
    logic             alu_c_s, alu_o_s, shl_in_s, slice_z_s, last_s;

    assign base_s      = {k_r, 3'b000};
    assign prev_idx_s  = base_s - 7'd1;
    assign last_s      = (k_r == 4'(NSLICE - 1));
    assign slice_a_s   = a_r[base_s +: DWIDTH];
    assign shl_in_s    = (k_r == 4'd0) ? 1'b0 : a_r[prev_idx_s];
    assign slice_res_s = (op_r == OP_SHL) ? {alu_y_s[7:1], shl_in_s} : alu_y_s;
    assign slice_z_s   = (slice_res_s == 8'h00);

    // Opcode remap: slice 0 runs the requested op, later slices chain carry/borrow
    always_comb begin
        slice_op_s = op_r;
        slice_b_s  = b_r[base_s +: DWIDTH];
        case (op_r)
            OP_ADD, OP_ADDINC, OP_INC: begin
                if (op_r == OP_INC) begin
                    slice_b_s = 8'h00;
                end else begin
                    slice_b_s = b_r[base_s +: DWIDTH];
                end
                if (k_r == 4'd0) begin
                    slice_op_s = op_r;
                end else begin
                    slice_op_s = carry_r ? OP_ADDINC : OP_ADD;
                end
            end
            OP_SUB, OP_SUBWB, OP_DEC: begin
                if (op_r == OP_DEC) begin
                    slice_b_s = 8'h00;
                end else begin
                    slice_b_s = b_r[base_s +: DWIDTH];
                end
                if (k_r == 4'd0) begin
                    slice_op_s = op_r;
                end else begin
                    slice_op_s = carry_r ? OP_SUBWB : OP_SUB;
                end
            end
            default: slice_op_s = op_r;
        endcase
    end

    alu_8bit u_alu (
        .op (slice_op_s),
        .a  (slice_a_s),
        .b  (slice_b_s),
        .y  (alu_y_s),
        .c  (alu_c_s),
        .o  (alu_o_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand capture, slice accumulation and final result/flag update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            op_r     <= 4'h0;
            k_r      <= 4'd0;
            carry_r  <= 1'b0;
            zacc_r   <= 1'b0;
            shadow_r <= {WIDTH{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= {WIDTH{1'b0}};
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
            o_flag   <= 1'b0;
            s_flag   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        op_r     <= opcode;
                        k_r      <= 4'd0;
                        carry_r  <= 1'b0;
                        zacc_r   <= 1'b1;
                        shadow_r <= {WIDTH{1'b0}};
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    shadow_r[base_s +: DWIDTH] <= slice_res_s;
                    carry_r <= alu_c_s;
                    zacc_r  <= zacc_r & slice_z_s;
                    k_r     <= k_r + 4'd1;
                    if (last_s) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        // top byte of shadow is still clear here, so OR merges slice 15
                        result <= {shadow_r[WIDTH-1 -: DWIDTH] | slice_res_s,
                                   shadow_r[WIDTH-DWIDTH-1:0]};
                        z_flag <= zacc_r & slice_z_s;
                        s_flag <= slice_res_s[7];
                        c_flag <= is_arith(op_r) ? alu_c_s :
                                  ((op_r == OP_SHL) ? a_r[WIDTH-1] : 1'b0);
                        o_flag <= is_arith(op_r) & alu_o_s;
                    end
                end
                ST_DONE: done <= 1'b0;
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu128_seq_ctrl.sv
// Scoreboard bench for alu128_seq_ctrl: driver queues expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu128_seq_ctrl;

    typedef struct packed {
        logic [127:0] r;
        logic         c;
        logic         z;
        logic         o;
        logic         s;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   opcode;
    logic [127:0] a, b;
    logic         busy, done;
    logic [127:0] result;
    logic         c_flag, z_flag, o_flag, s_flag;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    localparam logic [127:0] ALL1 = {128{1'b1}};

    always #5 clk = ~clk;

    alu128_seq_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_flag (c_flag),
        .z_flag (z_flag),
        .o_flag (o_flag),
        .s_flag (s_flag)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 128'd1, 128'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", result, mon_e.r);
                chk("c_flag", {127'd0, c_flag}, {127'd0, mon_e.c});
                chk("z_flag", {127'd0, z_flag}, {127'd0, mon_e.z});
                chk("o_flag", {127'd0, o_flag}, {127'd0, mon_e.o});
                chk("s_flag", {127'd0, s_flag}, {127'd0, mon_e.s});
            end
        end
    end

    task automatic launch(input logic [3:0] op, input logic [127:0] av, input logic [127:0] bv);
        @(negedge clk);
        opcode = op;
        a      = av;
        b      = bv;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called #1 after the accepting edge; measures edges until done
    task automatic wait_done(input bit timing);
        int cyc  = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1 cyc++;
        end
        if (!seen) begin
            chk("done_timeout", 128'd0, 128'd1);
        end else if (timing) begin
            chk("done_latency", 128'(cyc), 128'd16);
            chk("busy_cycles", 128'(bcnt), 128'd16);
        end
        @(negedge clk);
        #1;
        if (timing) begin
            @(posedge clk);
            #1;
            chk("done_pulse_width", {127'd0, done}, 128'd0);
            chk("busy_after_done", {127'd0, busy}, 128'd0);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [127:0] av, input logic [127:0] bv,
                       input exp_t e, input bit timing);
        sb_q.push_back(e);
        launch(op, av, bv);
        wait_done(timing);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0]   lops [4] = '{4'h8, 4'hA, 4'hB, 4'h9};
        logic [127:0] ra, rb, rr;
        exp_t         e;
        int           extra;

        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 4'h0;
        a      = 128'd0;
        b      = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_result", result, 128'd0);
        chk("reset_flags", {124'd0, c_flag, z_flag, o_flag, s_flag}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD all-ones + 1: carry ripples out of the top
        run(4'h0, ALL1, 128'd1, '{r: 128'd0, c: 1'b1, z: 1'b1, o: 1'b0, s: 1'b0}, 1'b1);
        // SUB 0 - 1: borrow ripples through every slice
        run(4'h3, 128'd0, 128'd1, '{r: ALL1, c: 1'b1, z: 1'b0, o: 1'b0, s: 1'b1}, 1'b0);
        // ADD signed overflow
        run(4'h0, {1'b0, {127{1'b1}}}, 128'd1,
            '{r: {1'b1, 127'd0}, c: 1'b0, z: 1'b0, o: 1'b1, s: 1'b1}, 1'b0);
        // INC 0xFF -> 0x100, b ignored
        run(4'h4, 128'h00FF, 128'h1234, '{r: 128'h0100, c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b0}, 1'b0);
        // DEC 0x100 -> 0xFF
        run(4'h5, 128'h0100, 128'h55, '{r: 128'h00FF, c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b0}, 1'b0);
        // SUBWB 5 - 3 - 1
        run(4'h1, 128'd5, 128'd3, '{r: 128'd1, c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b0}, 1'b0);
        // SHL across a slice boundary, then out of the top bit
        run(4'hD, 128'h0080, 128'd0, '{r: 128'h0100, c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b0}, 1'b0);
        run(4'hD, {1'b1, 127'd0}, 128'd0, '{r: 128'd0, c: 1'b1, z: 1'b1, o: 1'b0, s: 1'b0}, 1'b0);
        // Unassigned opcode
        run(4'h7, 128'h1234_5678_9ABC_DEF0, 128'h1111, '{r: 128'd0, c: 1'b0, z: 1'b1, o: 1'b0, s: 1'b0}, 1'b1);

        // Logic ops on random operands against a bitwise model
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom(), $urandom()};
            case (lops[i])
                4'h8:    rr = ra & rb;
                4'hA:    rr = ra ^ rb;
                4'hB:    rr = ~ra;
                default: rr = ra | rb;
            endcase
            e = '{r: rr, c: 1'b0, z: (rr == 128'd0), o: 1'b0, s: rr[127]};
            run(lops[i], ra, rb, e, 1'b0);
        end

        // Second start during RUN cycle 5 must be ignored
        sb_q.push_back('{r: 128'd123, c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b0});
        launch(4'h0, 128'd100, 128'd23);
        repeat (4) @(posedge clk);
        @(negedge clk);
        opcode = 4'h9;
        a      = ALL1;
        b      = ALL1;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b0);
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        chk("ignored_start_no_done", 128'(extra), 128'd0);

        // Reset asserted mid-RUN abandons the operation
        launch(4'h0, 128'd1, 128'd2);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_done", {127'd0, done}, 128'd0);
        chk("abort_result", result, 128'd0);
        chk("abort_flags", {124'd0, c_flag, z_flag, o_flag, s_flag}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_done_held", {127'd0, done}, 128'd0);

        // Start accepted on the first edge after reset release
        sb_q.push_back('{r: 128'd7, c: 1'b0, z: 1'b0, o: 1'b0, s: 1'b0});
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 4'h0;
        a      = 128'd3;
        b      = 128'd4;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b1);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
